// File: rtl/pipeline_ctrl_pkg.sv
// Shared types, constants and helpers for the pipeline stall controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Saturating increment on a 64-bit container; callers pass their own ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    if (value >= max_value) begin
      return value;
    end else begin
      return value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if_id_reg.sv
// IF/ID pipeline register: load on write enable, insert NOP on flush, else hold.
module if_id_reg
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            flush,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Flush has priority over write; an idle enable holds the decode slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= {XLEN{1'b0}};
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= {XLEN{1'b0}};
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (we) begin
      pc    <= in_pc;
      instr <= in_instr;
      valid <= 1'b1;
    end else begin
      pc    <= pc;
      instr <= instr;
      valid <= valid;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns load-use, branch and data-memory events into pipeline enables,
// owns the IF/ID register and the stall/flush performance counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  output logic             pc_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

  state_t state;
  state_t state_next;
  logic   if_id_we;
  logic   if_id_flush;
  logic   flush_evt;

  // State register; reset aborts any stall or wait in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control outputs; priority rst > dmem_busy > branch > load-use.
  always_comb begin
    state_next   = state;
    pc_write     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    flush_evt    = 1'b0;
    if (rst) begin
      id_ex_bubble = 1'b1;
      state_next   = RUN;
    end else begin
      case (state)
        MEM_WAIT: begin
          // Frozen while busy, plus one recovery cycle once it drops.
          ex_mem_hold = 1'b1;
          if (dmem_busy) begin
            state_next = MEM_WAIT;
          end else begin
            state_next = RUN;
          end
        end
        RUN, LU_BUBBLE: begin
          if (dmem_busy) begin
            ex_mem_hold = 1'b1;
            state_next  = MEM_WAIT;
          end else if (branch_taken) begin
            pc_write     = 1'b1;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            flush_evt    = 1'b1;
            state_next   = RUN;
          end else if (stall_req && (state == RUN)) begin
            // Only one bubble per load: in LU_BUBBLE the load is in MEM and forwards.
            id_ex_bubble = 1'b1;
            state_next   = LU_BUBBLE;
          end else begin
            pc_write   = 1'b1;
            if_id_we   = 1'b1;
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Saturating performance counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= {CNT_W{1'b0}};
      flush_count  <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write) begin
        stall_cycles <= CNT_W'(sat_inc(64'(stall_cycles), CNT_MAX));
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (flush_evt) begin
        flush_count <= CNT_W'(sat_inc(64'(flush_count), CNT_MAX));
      end else begin
        flush_count <= flush_count;
      end
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .we       (if_id_we),
    .flush    (if_id_flush),
    .in_pc    (if_pc),
    .in_instr (if_instr),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

endmodule
